// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Brief    : APB controller state encodings, shared with the legacy bridge.
// Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : apb_addr_decode
// Brief    : Address MSB field to one-hot slave select plus in-range flag.
// Revision : 1.0 - initial release
// ============================================================================
module apb_addr_decode #(
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_SLV    = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [NUM_SLV-1:0]    sel_o,
    output logic                  valid_o
);

    localparam int SEL_BITS = $clog2(NUM_SLV);

    logic [SEL_BITS-1:0] slv_idx;
    logic                unused_addr_lsbs;

    assign slv_idx          = addr_i[ADDR_WIDTH-1 -: SEL_BITS];
    assign unused_addr_lsbs = ^addr_i[ADDR_WIDTH-SEL_BITS-1:0];

    // Indices at or above NUM_SLV match no select bit, which flags the decode error.
    always_comb begin
        sel_o = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (slv_idx == SEL_BITS'(i)) begin
                sel_o[i] = 1'b1;
            end
        end
    end

    assign valid_o = |sel_o;

endmodule : apb_addr_decode
`default_nettype wire

// File: rtl/apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_ctrl
// Brief    : Multi-slave APB master with PSLVERR, ACCESS timeout and decode errors.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SLV    = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          pclk,
    input  logic                          preset_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [DATA_WIDTH-1:0]         req_wdata,
    output logic                          rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [NUM_SLV-1:0]            psel,
    output logic                          penable,
    output logic                          pwrite,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic [DATA_WIDTH-1:0]         pwdata,
    input  logic [NUM_SLV*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLV-1:0]            pready,
    input  logic [NUM_SLV-1:0]            pslverr
);

    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    apb_state_t              state_q, state_d;
    logic [NUM_SLV-1:0]      psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_pend_q, err_pend_d;

    logic [NUM_SLV-1:0]      dec_sel;
    logic                    dec_valid;
    logic                    pready_sel;
    logic                    pslverr_sel;
    logic [DATA_WIDTH-1:0]   prdata_sel;
    logic                    timeout_hit;
    logic                    accept;
    logic                    load;

    apb_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLV    (NUM_SLV)
    ) u_decode (
        .addr_i  (req_addr),
        .sel_o   (dec_sel),
        .valid_o (dec_valid)
    );

    // psel_q is one-hot while a transfer is active, so masking picks the latched slave.
    assign pready_sel  = |(pready & psel_q);
    assign pslverr_sel = |(pslverr & psel_q);

    always_comb begin
        prdata_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (psel_q[i]) begin
                prdata_sel = prdata_sel | prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (state_q == ST_ACCESS) && !pready_sel
                         && (cnt_q == CNT_LAST);

    // A queued decode error owns the response slot, so hold off one cycle behind it.
    assign req_ready = ((state_q == ST_IDLE) && !err_pend_q)
                     || ((state_q == ST_ACCESS) && pready_sel && !timeout_hit);
    assign accept    = req_valid && req_ready;
    assign load      = accept && dec_valid;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (timeout_hit) begin
                    state_d = ST_IDLE;
                end else if (pready_sel) begin
                    state_d = load ? ST_SETUP : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = err_pend_q;
        rsp_err_d   = err_pend_q;
        rsp_rdata_d = '0;
        err_pend_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept && !dec_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ST_ACCESS: begin
                if (timeout_hit) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (pready_sel) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr_sel;
                    if (!pwrite_q && !pslverr_sel) begin
                        rsp_rdata_d = prdata_sel;
                    end
                    err_pend_d  = accept && !dec_valid;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase

        if (load) begin
            psel_d    = dec_sel;
            penable_d = 1'b0;
            pwrite_d  = req_write;
            paddr_d   = req_addr;
            pwdata_d  = req_wdata;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            err_pend_q  <= 1'b0;
        end else begin
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_pend_q  <= err_pend_d;
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule : apb_master_ctrl
`default_nettype wire

// File: tb/tb_apb_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_ctrl
// Brief    : Directed bench: 4-slave/TIMEOUT=8 instance plus 3-slave decode-error instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_ctrl;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;

    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic [3:0]  psel;
    logic        penable, pwrite;
    logic [15:0] paddr, pwdata;
    logic [63:0] prdata;
    logic [3:0]  pready, pslverr;

    logic        d3_req_valid, d3_req_ready, d3_req_write;
    logic [15:0] d3_req_addr, d3_req_wdata;
    logic        d3_rsp_valid, d3_rsp_err;
    logic [15:0] d3_rsp_rdata;
    logic [2:0]  d3_psel;
    logic        d3_penable, d3_pwrite;
    logic [15:0] d3_paddr, d3_pwdata;
    logic [47:0] d3_prdata;
    logic [2:0]  d3_pready, d3_pslverr;

    int vec_cnt = 0;
    int err_cnt = 0;
    int n;

    always #5 pclk = ~pclk;

    apb_master_ctrl #(
        .ADDR_WIDTH (16), .DATA_WIDTH (16), .NUM_SLV (4), .TIMEOUT (8)
    ) u_dut (
        .pclk (pclk), .preset_n (preset_n),
        .req_valid (req_valid), .req_ready (req_ready), .req_write (req_write),
        .req_addr (req_addr), .req_wdata (req_wdata),
        .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err),
        .psel (psel), .penable (penable), .pwrite (pwrite),
        .paddr (paddr), .pwdata (pwdata),
        .prdata (prdata), .pready (pready), .pslverr (pslverr)
    );

    apb_master_ctrl #(
        .ADDR_WIDTH (16), .DATA_WIDTH (16), .NUM_SLV (3), .TIMEOUT (8)
    ) u_dut3 (
        .pclk (pclk), .preset_n (preset_n),
        .req_valid (d3_req_valid), .req_ready (d3_req_ready), .req_write (d3_req_write),
        .req_addr (d3_req_addr), .req_wdata (d3_req_wdata),
        .rsp_valid (d3_rsp_valid), .rsp_rdata (d3_rsp_rdata), .rsp_err (d3_rsp_err),
        .psel (d3_psel), .penable (d3_penable), .pwrite (d3_pwrite),
        .paddr (d3_paddr), .pwdata (d3_pwdata),
        .prdata (d3_prdata), .pready (d3_pready), .pslverr (d3_pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
        $fatal(1);
    end

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        prdata  = {16'hDEAD, 16'h1234, 16'h7777, 16'h5555};
        pready  = '0;
        pslverr = '0;
        d3_req_valid = 1'b0; d3_req_write = 1'b0; d3_req_addr = '0; d3_req_wdata = '0;
        d3_prdata  = 48'h0000_0000_ABCD;
        d3_pready  = 3'b111;
        d3_pslverr = '0;

        // Reset state
        #12;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_d3_psel", d3_psel, 0);
        @(negedge pclk);
        preset_n = 1'b1;
        step();

        // Zero-wait write to slave 1
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h4010; req_wdata = 16'hA5A5;
        pready = 4'b0010;
        #1;
        chk("zw_req_ready_idle", req_ready, 1);
        step();
        req_valid = 1'b0;
        chk("zw_setup_psel", psel, 4'b0010);
        chk("zw_setup_penable", penable, 0);
        chk("zw_setup_paddr", paddr, 16'h4010);
        chk("zw_setup_pwdata", pwdata, 16'hA5A5);
        chk("zw_setup_pwrite", pwrite, 1);
        chk("zw_setup_req_ready", req_ready, 0);
        step();
        chk("zw_access_penable", penable, 1);
        chk("zw_access_rsp_valid", rsp_valid, 0);
        step();
        chk("zw_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 16'h0000});
        chk("zw_idle_psel", psel, 0);
        chk("zw_idle_paddr_hold", paddr, 16'h4010);
        step();
        chk("zw_rsp_pulse", rsp_valid, 0);

        // Read from slave 2 with two wait states; other slaves' ready/err must be ignored
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h8000;
        pready = 4'b1011; pslverr = 4'b1011;
        step();
        req_valid = 1'b0;
        chk("ws_setup_psel", psel, 4'b0100);
        step();
        chk("ws_acc1_penable", penable, 1);
        chk("ws_acc1_req_ready", req_ready, 0);
        step();
        chk("ws_acc2_penable", penable, 1);
        step();
        chk("ws_acc3_penable", penable, 1);
        pready = 4'b0100;
        #1;
        chk("ws_acc3_req_ready", req_ready, 1);
        step();
        chk("ws_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 16'h1234});
        pready = '0; pslverr = '0;
        step();

        // Back-to-back: write slave 0, then read slave 3 with req_valid held
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0008; req_wdata = 16'h1111;
        pready = 4'b1001;
        step();
        req_write = 1'b0; req_addr = 16'hC002;
        chk("b2b_a_psel", psel, 4'b0001);
        chk("b2b_a_setup_ready", req_ready, 0);
        step();
        chk("b2b_a_access_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        chk("b2b_b_setup_psel", psel, 4'b1000);
        chk("b2b_b_setup_penable", penable, 0);
        chk("b2b_b_setup_paddr", paddr, 16'hC002);
        chk("b2b_b_setup_pwrite", pwrite, 0);
        chk("b2b_a_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 16'h0000});
        step();
        chk("b2b_b_access", {psel, penable}, {4'b1000, 1'b1});
        chk("b2b_b_no_rsp", rsp_valid, 0);
        step();
        chk("b2b_b_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 16'hDEAD});
        chk("b2b_b_idle_psel", psel, 0);
        pready = '0;
        step();

        // PSLVERR on a read from slave 1
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h4000;
        pready = 4'b0010; pslverr = 4'b0010;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("slverr_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 16'h0000});
        pready = '0; pslverr = '0;
        step();

        // Timeout: slave 0 never ready while others are
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0004; req_wdata = 16'h0F0F;
        pready = 4'b1110;
        step();
        req_valid = 1'b0;
        step();
        n = 0;
        while (penable && n < 20) begin
            n++;
            step();
        end
        chk("to_access_cycles", n, 8);
        chk("to_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 16'h0000});
        chk("to_psel", psel, 0);
        step();
        chk("to_rsp_pulse", rsp_valid, 0);
        pready = '0;

        // Asynchronous reset in the middle of ACCESS
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h8000;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("mid_pre_rst_penable", penable, 1);
        preset_n = 1'b0;
        #1;
        chk("mid_rst_apb", {psel, penable, pwrite, paddr, pwdata}, 0);
        chk("mid_rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        pready = 4'b0100;
        @(negedge pclk);
        preset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_post_rst_no_rsp", {rsp_valid, penable}, 0);
        end
        pready = '0;

        // Decode error on the 3-slave instance (index 3 out of range)
        d3_req_valid = 1'b1; d3_req_write = 1'b0; d3_req_addr = 16'hC000;
        step();
        d3_req_valid = 1'b0;
        chk("dec_psel", d3_psel, 0);
        chk("dec_rsp", {d3_rsp_valid, d3_rsp_err, d3_rsp_rdata}, {1'b1, 1'b1, 16'h0000});
        chk("dec_req_ready", d3_req_ready, 1);
        step();
        chk("dec_rsp_pulse", d3_rsp_valid, 0);

        // Back-to-back valid write followed by an out-of-range request
        d3_req_valid = 1'b1; d3_req_write = 1'b1; d3_req_addr = 16'h0000; d3_req_wdata = 16'h2222;
        step();
        d3_req_addr = 16'hC000;
        chk("d3b2b_psel", d3_psel, 3'b001);
        step();
        chk("d3b2b_access_ready", d3_req_ready, 1);
        step();
        d3_req_valid = 1'b0;
        chk("d3b2b_wr_rsp", {d3_rsp_valid, d3_rsp_err}, 2'b10);
        chk("d3b2b_idle_psel", {d3_psel, d3_penable}, 0);
        step();
        chk("d3b2b_dec_rsp", {d3_rsp_valid, d3_rsp_err, d3_rsp_rdata}, {1'b1, 1'b1, 16'h0000});
        step();
        chk("d3b2b_rsp_done", d3_rsp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_apb_master_ctrl
`default_nettype wire
